// File: rtl/sram_controller.sv
// Bridges a 32-bit load/store port to a 16-bit async SRAM as two half-word accesses, low half first.
// Latency: ready low for 2*WAIT_CYCLES+1 cycles per request, high for one DONE cycle; requests are held until ready.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);
    localparam logic [3:0]  LastCnt  = 4'(WAIT_CYCLES - 1);

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic        opWrite;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic [17:0] addrHold;
    logic        req, busy, lastWait, driveBus;
    logic [16:0] idxIn;

    assign req      = wr_en | rd_en;
    assign busy     = (state == LOW) || (state == HIGH);
    assign lastWait = (cnt == LastCnt);
    assign driveBus = busy && opWrite;
    // Out-of-range addresses simply wrap onto the SRAM.
    assign idxIn    = 17'((address - BaseAddr) >> 2);

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    cntNext   = 4'd0;
                    stateNext = LOW;
                end
            end
            LOW: begin
                if (lastWait) begin
                    cntNext   = 4'd0;
                    stateNext = HIGH;
                end else begin
                    cntNext = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (lastWait) begin
                    cntNext   = 4'd0;
                    stateNext = DONE;
                end else begin
                    cntNext = cnt + 4'd1;
                end
            end
            DONE: begin
                ready     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The address bus only moves during an access and otherwise parks on its last value.
    assign sram_addr = busy ? {idx, state == HIGH} : addrHold;
    assign sram_we_n = ~driveBus;
    assign sram_dq   = driveBus ? ((state == HIGH) ? wdata[31:16] : wdata[15:0]) : 16'bz;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            opWrite   <= 1'b0;
            idx       <= 17'd0;
            wdata     <= 32'd0;
            addrHold  <= 18'd0;
            read_data <= 32'd0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            addrHold <= sram_addr;
            // Write wins when both enables are high.
            if (state == IDLE && req) begin
                opWrite <= wr_en;
                idx     <= idxIn;
                wdata   <= write_data;
            end
            if (busy && !opWrite && lastWait) begin
                if (state == HIGH) read_data[31:16] <= sram_dq;
                else               read_data[15:0]  <= sram_dq;
            end
        end
    end

endmodule
